// File: rtl/acc_mul_pipe.sv
// Purpose: pipelined W x W approximate multiplier built from four H x H quadrant products with per-beat modes.
// Latency: 3 cycles from input transfer to out_valid (S1 operands, S2 quadrants, S3 product).
// Backpressure: a single global enable (!out_valid || out_ready) advances or freezes every stage; in_ready = enable.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready with a, b, mode (input beat);
//        out_valid/out_ready with prod (output beat).
// Mode per quadrant (2 bits): 00 exact, 01 clear low H/2 bits, 10 clear low H bits, 11 zero.
// Optional: define ACC_MUL_ERR_MON_EN to add err (exact - prod, aligned with prod) and
//           err_cnt (saturating count of transferred beats with nonzero err).
module acc_mul_pipe #(
  parameter int W = 8  // operand width, must be even and >= 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [7:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod
`ifdef ACC_MUL_ERR_MON_EN
  ,
  output logic [2*W-1:0] err,
  output logic [15:0]    err_cnt
`endif
);

  localparam int H = W / 2;   // quadrant width
  localparam int Q = 2 * H;   // quadrant product width
  localparam int P = 2 * W;   // full product width

  localparam logic [Q-1:0] MASK_HALF = {Q{1'b1}} << (H / 2);
  localparam logic [Q-1:0] MASK_LOW  = {Q{1'b1}} << H;

  // Each mode only clears bits, so a moded quadrant never exceeds the exact one.
  function automatic logic [Q-1:0] f_apply_mode(input logic [Q-1:0] q, input logic [1:0] m);
    case (m)
      2'b00:   return q;
      2'b01:   return q & MASK_HALF;
      2'b10:   return q & MASK_LOW;
      default: return '0;
    endcase
  endfunction

  logic           w_en;

  // S1: operands and mode
  logic           r_s1_vld;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [7:0]     r_mode;

  // S2: moded quadrant products
  logic           r_s2_vld;
  logic [Q-1:0]   r_ll;
  logic [Q-1:0]   r_lh;
  logic [Q-1:0]   r_hl;
  logic [Q-1:0]   r_hh;

  // S3: product
  logic           r_s3_vld;
  logic [P-1:0]   r_prod;

  logic [Q-1:0]   w_ll_raw;
  logic [Q-1:0]   w_lh_raw;
  logic [Q-1:0]   w_hl_raw;
  logic [Q-1:0]   w_hh_raw;
  logic [Q:0]     w_mid;
  logic [P-1:0]   w_sum;

  assign w_en      = !r_s3_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_s3_vld;
  assign prod      = r_prod;

  assign w_ll_raw = {{H{1'b0}}, r_a[H-1:0]} * {{H{1'b0}}, r_b[H-1:0]};
  assign w_lh_raw = {{H{1'b0}}, r_a[H-1:0]} * {{H{1'b0}}, r_b[W-1:H]};
  assign w_hl_raw = {{H{1'b0}}, r_a[W-1:H]} * {{H{1'b0}}, r_b[H-1:0]};
  assign w_hh_raw = {{H{1'b0}}, r_a[W-1:H]} * {{H{1'b0}}, r_b[W-1:H]};

  // Cross terms share a weight, so add them first with one carry bit of headroom.
  assign w_mid = {1'b0, r_lh} + {1'b0, r_hl};
  assign w_sum = {{(P-Q){1'b0}}, r_ll}
               + ({{(P-Q-1){1'b0}}, w_mid} << H)
               + {r_hh, {W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= '0;
      r_s2_vld <= 1'b0;
      r_ll     <= '0;
      r_lh     <= '0;
      r_hl     <= '0;
      r_hh     <= '0;
      r_s3_vld <= 1'b0;
      r_prod   <= '0;
    end else if (w_en) begin
      // Stages shift as a whole; bubbles travel with the data rather than collapsing.
      r_s1_vld <= in_valid;
      r_a      <= a;
      r_b      <= b;
      r_mode   <= mode;
      r_s2_vld <= r_s1_vld;
      r_ll     <= f_apply_mode(w_ll_raw, r_mode[1:0]);
      r_lh     <= f_apply_mode(w_lh_raw, r_mode[3:2]);
      r_hl     <= f_apply_mode(w_hl_raw, r_mode[5:4]);
      r_hh     <= f_apply_mode(w_hh_raw, r_mode[7:6]);
      r_s3_vld <= r_s2_vld;
      r_prod   <= w_sum;
    end
  end

`ifdef ACC_MUL_ERR_MON_EN
  logic [P-1:0] r_exact;
  logic [P-1:0] r_err;
  logic [15:0]  r_err_cnt;

  assign err     = r_err;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exact <= '0;
      r_err   <= '0;
    end else if (w_en) begin
      r_exact <= {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
      // Never negative: the approximate sum is bounded above by the exact product.
      r_err   <= r_exact - w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_s3_vld && out_ready && (r_err != '0) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_mul_pipe.sv
// Purpose: directed and streaming checks of acc_mul_pipe (W=8 instance plus a W=16 instance).
// Latency: expects out_valid on the third rising edge counting the accepting edge as the first.
// Backpressure: drives out_ready stalls and random out_ready, checking order and hold behaviour.
module tb_acc_mul_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [7:0]  mode16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] prod16;

`ifdef ACC_MUL_ERR_MON_EN
  logic [15:0] err;
  logic [15:0] err_cnt;
  logic [31:0] err16;
  logic [15:0] err_cnt16;
`endif

  int n_checks;
  int n_errors;
  int exp_cnt;

  acc_mul_pipe #(.W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
`ifdef ACC_MUL_ERR_MON_EN
    ,
    .err       (err),
    .err_cnt   (err_cnt)
`endif
  );

  acc_mul_pipe #(.W(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .mode      (mode16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .prod      (prod16)
`ifdef ACC_MUL_ERR_MON_EN
    ,
    .err       (err16),
    .err_cnt   (err_cnt16)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: quadrant clearing written as subtraction of a remainder.
  function automatic int qmode(input int q, input logic [1:0] m);
    case (m)
      2'd0:    return q;
      2'd1:    return q - (q % 4);
      2'd2:    return q - (q % 16);
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] fa, input logic [7:0] fb,
                                           input logic [7:0] fm);
    int al, ah, bl, bh, r;
    al = int'(fa[3:0]);
    ah = int'(fa[7:4]);
    bl = int'(fb[3:0]);
    bh = int'(fb[7:4]);
    r  = qmode(al * bl, fm[1:0])
       + (qmode(al * bh, fm[3:2]) + qmode(ah * bl, fm[5:4])) * 16
       + qmode(ah * bh, fm[7:6]) * 256;
    return r[15:0];
  endfunction

  task automatic single_beat(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tm,
                             input logic [15:0] exp, input string name);
    int cyc;
    logic [15:0] exact;
    exact = {8'h00, ta} * {8'h00, tb};
    a = ta; b = tb; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
    end
    n_checks++;
    if (cyc !== 3) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges required 3", name, cyc);
    end
    n_checks++;
    if (prod !== exp) begin
      n_errors++;
      $display("FAIL %s prod: got %h required %h", name, prod, exp);
    end
`ifdef ACC_MUL_ERR_MON_EN
    n_checks++;
    if (err !== (exact - exp)) begin
      n_errors++;
      $display("FAIL %s err: got %h required %h", name, err, exact - exp);
    end
    if (exact != exp) exp_cnt++;
`endif
    @(posedge clk); #1;
`ifdef ACC_MUL_ERR_MON_EN
    n_checks++;
    if (err_cnt !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL %s err_cnt: got %0d required %0d", name, err_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_valid16 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset out_valid: got %b/%b required 0/0", out_valid, out_valid16);
    end
    n_checks++;
    if (prod !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset prod: got %h required 0000", prod);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset in_ready: got %b required 1", in_ready);
    end
`ifdef ACC_MUL_ERR_MON_EN
    n_checks++;
    if (err !== 16'h0 || err_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL reset err: got %h/%h required 0/0", err, err_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    single_beat(8'hFF, 8'hFF, 8'h00, 16'hFE01, "max_exact");
    single_beat(8'hFF, 8'hFF, 8'h02, 16'hFE00, "max_ll10");
    single_beat(8'h03, 8'h03, 8'h01, 16'h0008, "3x3_m01");
    single_beat(8'h03, 8'h03, 8'h02, 16'h0000, "3x3_m02");
    single_beat(8'h03, 8'h03, 8'hFC, 16'h0009, "3x3_mFC");
    single_beat(8'h00, 8'hA5, 8'h00, 16'h0000, "zero_a");
    single_beat(8'h5A, 8'h00, 8'h55, 16'h0000, "zero_b");
    single_beat(8'h00, 8'hFF, 8'hFF, 16'h0000, "zero_all_modes");
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0001; exp_v[1] = 16'h0004; exp_v[2] = 16'h0009;
    out_ready = 1'b1; in_valid = 1'b1; mode = 8'h00;
    a = 8'd1; b = 8'd1; @(posedge clk); #1;
    a = 8'd2; b = 8'd2; @(posedge clk); #1;
    a = 8'd3; b = 8'd3; @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b first out_valid: got %b required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || prod !== 16'h0001) begin
        n_errors++;
        $display("FAIL b2b stall cycle %0d: in_ready=%b out_valid=%b prod=%h required 0 1 0001",
                 i, in_ready, out_valid, prod);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(prod);
      @(posedge clk); #1;
    end
    n_checks++;
    if (got.size() !== 3) begin
      n_errors++;
      $display("FAIL b2b count: got %0d beats required 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== exp_v[i]) begin
          n_errors++;
          $display("FAIL b2b beat %0d: got %h required %h", i, got[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [15:0] q[$];
    logic [15:0] qe[$];
    logic [15:0] exp_p;
    logic [15:0] exp_e;
    int sent, nout, cyc;
    bit acc;
    sent = 0; nout = 0; cyc = 0;
    in_valid = 1'b0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        mode = 8'($urandom_range(0, 255));
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        nout++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL stream spurious output: prod=%h required none", prod);
        end else begin
          exp_p = q.pop_front();
          exp_e = qe.pop_front();
          if (prod !== exp_p) begin
            n_errors++;
            $display("FAIL stream beat %0d: got %h required %h", nout, prod, exp_p);
          end
`ifdef ACC_MUL_ERR_MON_EN
          if (exp_e != 16'h0) exp_cnt++;
`endif
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(ref_prod(a, b, mode));
        qe.push_back(({8'h00, a} * {8'h00, b}) - ref_prod(a, b, mode));
        sent++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (cyc >= 3000) begin
      n_errors++;
      $display("FAIL stream timeout: sent=%0d outputs=%0d required 100/100", sent, nout);
    end
    n_checks++;
    if (nout !== sent || sent !== 100) begin
      n_errors++;
      $display("FAIL stream counts: in=%0d out=%0d required 100/100", sent, nout);
    end
`ifdef ACC_MUL_ERR_MON_EN
    n_checks++;
    if (err_cnt !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL stream err_cnt: got %0d required %0d", err_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; in_valid = 1'b1; mode = 8'h00;
    a = 8'd4; b = 8'd4; @(posedge clk); #1;
    a = 8'd5; b = 8'd5; @(posedge clk); #1;
    a = 8'd6; b = 8'd6; @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || prod !== 16'h0000) begin
      n_errors++;
      $display("FAIL midreset outputs: out_valid=%b prod=%h required 0 0000", out_valid, prod);
    end
`ifdef ACC_MUL_ERR_MON_EN
    exp_cnt = 0;
    n_checks++;
    if (err_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL midreset err_cnt: got %0d required 0", err_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    single_beat(8'h10, 8'h10, 8'h00, 16'h0100, "post_reset");
  endtask

  task automatic test_w16();
    int cyc;
    a16 = 16'hFFFF; b16 = 16'hFFFF; mode16 = 8'h00; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    cyc = 1;
    while (!out_valid16 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (out_valid16 !== 1'b1 || cyc !== 3) begin
      n_errors++;
      $display("FAIL w16 latency: out_valid=%b edges=%0d required 1 3", out_valid16, cyc);
    end
    n_checks++;
    if (prod16 !== 32'hFFFE0001) begin
      n_errors++;
      $display("FAIL w16 prod: got %h required FFFE0001", prod16);
    end
`ifdef ACC_MUL_ERR_MON_EN
    n_checks++;
    if (err16 !== 32'h0) begin
      n_errors++;
      $display("FAIL w16 err: got %h required 0", err16);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_cnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; mode = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; mode16 = '0; out_ready16 = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_stream();
    test_reset_midflight();
    test_w16();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
